// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared half-adder pair plus a carry flop, stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output: define SERIAL_ADD_OVF_EN to build the ovf port.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             h1;
    logic             c1;
    logic             s_bit;
    logic             c2;
    logic             c_next;
    logic [WIDTH-1:0] s_final;

    // Shared bit cell: two half adders plus carry merge.
    assign h1      = a_sr[0] ^ b_sr[0];
    assign c1      = a_sr[0] & b_sr[0];
    assign s_bit   = h1 ^ carry;
    assign c2      = h1 & carry;
    assign c_next  = c1 | c2;
    assign s_final = {s_bit, s_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        s_sr  <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_final;
                    carry <= c_next;
                    cnt   <= cnt + CNT_W'(1);
                    // On the MSB step the operand shifters still hold the MSBs of a and b.
                    if (cnt == LAST_BIT) begin
                        sum   <= s_final;
                        cout  <= c_next;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= (a_sr[0] == b_sr[0]) && (s_bit != a_sr[0]);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): fixed vectors, corner sequences, random operands vs arithmetic model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;
    localparam int MAX_WAIT = 20;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int vectors;
    int miscompares;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition and the two's-complement overflow rule.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv};
        es   = full[W-1:0];
        ec   = full[W];
        eo   = (av[W-1] == bv[W-1]) && (es[W-1] != av[W-1]);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) check({tag, ".ovf_model"}, 32'(eo), 32'd0);
`endif
    endtask

    // One complete operation; optionally pulses start with a=0x55 during RUN after sample `inject`.
    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] es, input logic ec, input logic eo, input int inject);
        logic [W-1:0] prev;
        int lat, busy_n, bad;
        logic got;
        prev = sum;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        busy_n = 0; bad = 0; lat = 0; got = 1'b0;
        if (busy) busy_n++;
        if (sum !== prev) bad++;
        while (!got && lat < MAX_WAIT) begin
            if (inject > 0 && lat == inject) begin start = 1'b1; a = 8'h55; b = 8'h55; end
            if (inject > 0 && lat == inject + 1) start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
            else begin
                if (busy) busy_n++;
                if (sum !== prev) bad++;
            end
            if (done && busy) bad++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'd8);
        check_result(tag, es, ec, eo);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, ".stable_while_busy"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, ".sum_held"}, 32'(sum), 32'(es));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < MAX_WAIT);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic ec, eo;
        int n, done_seen;

        vectors = 0; miscompares = 0;
        tbl[0] = '{a: 8'h0F, b: 8'h01, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        tbl[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        tbl[4] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        tbl[5] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1, ovf: 1'b0};
        tbl[6] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        tbl[7] = '{a: 8'h40, b: 8'h40, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        tbl[8] = '{a: 8'h10, b: 8'h20, sum: 8'h30, cout: 1'b0, ovf: 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy_done", 32'({busy, done}), 32'd0);
        check_result("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0);

        // Start during RUN is ignored.
        op("ignore_start", 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 2);

        // Start held high: back-to-back issue every 9 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02;
        @(posedge clk); #1;
        a = 8'h03; b = 8'h04;
        wait_done(n);
        check("b2b.first_latency", 32'(n), 32'd8);
        check_result("b2b.first", 8'h03, 1'b0, 1'b0);
        wait_done(n);
        start = 1'b0;
        check("b2b.interval", 32'(n), 32'd9);
        check_result("b2b.second", 8'h07, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("b2b.idle_after", 32'({busy, done}), 32'd0);

        // Reset mid-RUN clears outputs at once and suppresses done.
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.busy_done", 32'({busy, done}), 32'd0);
        check_result("midrst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst.no_done", 32'(done_seen), 32'd0);
        op("post_rst", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            model(ra, rb, es, ec, eo);
            op($sformatf("rand%0d_%02h_%02h", i, ra, rb), ra, rb, es, ec, eo, (i % 4 == 0) ? 1 + (i % 5) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
